// File: rtl/trigger_channel_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// Package : triggerer_pkg
// Brief   : Shared triggerer constants, arbiter states and output word packing.
// Rev     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package triggerer_pkg;

   localparam int NUM_CHANNELS   = 4;
   localparam int CH_ID_WIDTH    = 2;
   localparam int TS_WIDTH       = 22;
   localparam int OUT_WORD_WIDTH = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      POP   = 2'd2
   } arb_state_t;

   // The host decoder splits words as {channel id, timestamp}.
   function automatic logic [OUT_WORD_WIDTH-1:0] pack_word(
      input logic [CH_ID_WIDTH-1:0] ch_id,
      input logic [TS_WIDTH-1:0]    ts
   );
      return {ch_id, ts};
   endfunction

endpackage

`default_nettype wire

// File: rtl/trigger_channel_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// Module : rr_pick
// Brief  : Combinational round-robin search, first eligible after last.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_pick #(
   parameter int N_REQ    = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [N_REQ-1:0]    eligible,
   input  logic [ID_WIDTH-1:0] last,
   output logic                found,
   output logic [ID_WIDTH-1:0] pick
);

   logic [ID_WIDTH-1:0] idx;

   // Walk last+1 .. last+N_REQ with explicit wrap so non-power-of-two counts work.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = last;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (idx == ID_WIDTH'(N_REQ - 1)) ? '0 : idx + 1'b1;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/trigger_channel_arbiter.sv
// ---------------------------------------------------------------------------
// Module : trigger_channel_arbiter
// Brief  : Round-robin share of the serial output shifter among channel queues.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trigger_channel_arbiter
   import triggerer_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_CHANNELS-1:0]            ch_valid,
   input  logic [NUM_CHANNELS*TS_WIDTH-1:0]   ch_data,
   input  logic [NUM_CHANNELS-1:0]            ch_enable,
   input  logic                               word_fetched,
   output logic [NUM_CHANNELS-1:0]            ch_pop,
   output logic [OUT_WORD_WIDTH-1:0]          word_to_tx,
   output logic                               dat_rdy,
   output logic [CH_ID_WIDTH-1:0]             grant_id,
   output logic                               underrun
);

   arb_state_t                  state_q, state_d;
   logic [CH_ID_WIDTH-1:0]      grant_id_q, grant_id_d;
   logic [CH_ID_WIDTH-1:0]      last_q, last_d;
   logic [OUT_WORD_WIDTH-1:0]   word_q, word_d;
   logic                        underrun_q, underrun_d;

   logic [NUM_CHANNELS-1:0]     eligible;
   logic                        found;
   logic [CH_ID_WIDTH-1:0]      pick;
   logic [TS_WIDTH-1:0]         pick_ts;

   assign eligible = ch_valid & ch_enable;

   rr_pick #(
      .N_REQ    (NUM_CHANNELS),
      .ID_WIDTH (CH_ID_WIDTH)
   ) u_rr_pick (
      .eligible (eligible),
      .last     (last_q),
      .found    (found),
      .pick     (pick)
   );

   always_comb begin
      pick_ts = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (pick == CH_ID_WIDTH'(i)) begin
            pick_ts = ch_data[i*TS_WIDTH +: TS_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         last_q     <= CH_ID_WIDTH'(NUM_CHANNELS - 1);
         word_q     <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_q     <= last_d;
         word_q     <= word_d;
         underrun_q <= underrun_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      last_d     = last_q;
      word_d     = word_q;
      underrun_d = underrun_q;

      // A fetch with nothing presented means the shifter sent a stale word.
      if (word_fetched && (state_q != GRANT)) begin
         underrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_id_d = pick;
               last_d     = pick;
               word_d     = pack_word(pick, pick_ts);
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (word_fetched) begin
               state_d = POP;
            end
         end
         POP: begin
            // Holdoff cycle: the queue head updates before the next decision.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      ch_pop = '0;
      if (state_q == POP) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            ch_pop[i] = (grant_id_q == CH_ID_WIDTH'(i));
         end
      end
   end

   assign dat_rdy    = (state_q == GRANT);
   assign word_to_tx = word_q;
   assign grant_id   = grant_id_q;
   assign underrun   = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_channel_arbiter.sv
// ---------------------------------------------------------------------------
// Module : tb_trigger_channel_arbiter
// Brief  : Self-checking bench with queue-level round-robin reference model.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trigger_channel_arbiter;
   import triggerer_pkg::*;

   logic                             clk = 1'b0;
   logic                             rst_n;
   logic [NUM_CHANNELS-1:0]          ch_valid;
   logic [NUM_CHANNELS*TS_WIDTH-1:0] ch_data;
   logic [NUM_CHANNELS-1:0]          ch_enable;
   logic                             word_fetched;
   logic [NUM_CHANNELS-1:0]          ch_pop;
   logic [OUT_WORD_WIDTH-1:0]        word_to_tx;
   logic                             dat_rdy;
   logic [CH_ID_WIDTH-1:0]           grant_id;
   logic                             underrun;

   int checks   = 0;
   int failures = 0;
   int exp_last = NUM_CHANNELS - 1;
   int got;
   int exp_ch;
   logic [TS_WIDTH-1:0] ts_q [NUM_CHANNELS][$];

   trigger_channel_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ch_valid     (ch_valid),
      .ch_data      (ch_data),
      .ch_enable    (ch_enable),
      .word_fetched (word_fetched),
      .ch_pop       (ch_pop),
      .word_to_tx   (word_to_tx),
      .dat_rdy      (dat_rdy),
      .grant_id     (grant_id),
      .underrun     (underrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Queue heads drive the channel inputs, as the per-channel falling queues would.
   task automatic refresh();
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         ch_valid[i] = (ts_q[i].size() != 0);
         ch_data[i*TS_WIDTH +: TS_WIDTH] = (ts_q[i].size() != 0) ? ts_q[i][0] : '0;
      end
   endtask

   function automatic int rr_next(input logic [NUM_CHANNELS-1:0] elig, input int last);
      for (int k = 1; k <= NUM_CHANNELS; k++) begin
         if (elig[(last + k) % NUM_CHANNELS]) return (last + k) % NUM_CHANNELS;
      end
      return -1;
   endfunction

   task automatic wait_rdy();
      int n = 0;
      while (dat_rdy !== 1'b1 && n < 6) begin
         step();
         n++;
      end
      check("dat_rdy_wait", {31'd0, dat_rdy}, 32'd1);
   endtask

   // One full transaction: grant, optional hold, fetch, pop.
   task automatic serve(input int hold, input bit perturb, output int got_ch);
      logic [OUT_WORD_WIDTH-1:0] exp_word;
      logic [TS_WIDTH-1:0]       head;
      int                        ch;
      ch     = rr_next(ch_valid & ch_enable, exp_last);
      got_ch = -1;
      wait_rdy();
      if (dat_rdy !== 1'b1 || ch < 0) return;
      head     = ts_q[ch][0];
      exp_word = {ch[CH_ID_WIDTH-1:0], head};
      got_ch   = int'(grant_id);
      check("grant_id", 32'(grant_id), ch);
      check("word", 32'(word_to_tx), 32'(exp_word));
      for (int h = 0; h < hold; h++) begin
         if (perturb) ch_data[ch*TS_WIDTH +: TS_WIDTH] = ~head;
         step();
         check("word_hold", 32'(word_to_tx), 32'(exp_word));
         check("rdy_hold", {31'd0, dat_rdy}, 32'd1);
      end
      if (perturb) refresh();
      word_fetched = 1'b1;
      step();
      word_fetched = 1'b0;
      check("pop_onehot", 32'(ch_pop), 32'(1) << ch);
      check("pop_rdy_low", {31'd0, dat_rdy}, 32'd0);
      void'(ts_q[ch].pop_front());
      exp_last = ch;
      refresh();
      step();
      check("pop_single", 32'(ch_pop), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n        = 1'b0;
      ch_valid     = '0;
      ch_data      = '0;
      ch_enable    = '0;
      word_fetched = 1'b0;
      step();
      step();
      check("rst_dat_rdy", {31'd0, dat_rdy}, 32'd0);
      check("rst_ch_pop", 32'(ch_pop), 32'd0);
      check("rst_word", 32'(word_to_tx), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      rst_n = 1'b1;
      step();

      // Single channel, fixed value, one-cycle grant latency.
      ts_q[0].push_back(22'h12345);
      ch_enable = '1;
      refresh();
      step();
      check("lat_dat_rdy", {31'd0, dat_rdy}, 32'd1);
      check("lat_word", 32'(word_to_tx), 32'h0012345);
      check("lat_grant", 32'(grant_id), 32'd0);
      serve(1, 1'b0, got);

      // Fetch with nothing presented.
      word_fetched = 1'b1;
      step();
      word_fetched = 1'b0;
      check("underrun_set", {31'd0, underrun}, 32'd1);
      check("underrun_no_pop", 32'(ch_pop), 32'd0);
      step();
      check("underrun_idle", {31'd0, dat_rdy}, 32'd0);

      // All four busy; channel 0 was served last so the rotation starts at 1.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         ts_q[i].push_back(TS_WIDTH'($urandom));
         ts_q[i].push_back(TS_WIDTH'($urandom));
      end
      refresh();
      for (int i = 0; i < 8; i++) begin
         serve($urandom_range(0, 2), 1'b0, got);
         check("rr_order", got, (i + 1) % NUM_CHANNELS);
         if (got >= 0) ts_q[got].push_back(TS_WIDTH'($urandom));
         refresh();
      end
      check("underrun_sticky", {31'd0, underrun}, 32'd1);

      // Channel 3 valid but disabled; only channel 1 may be granted.
      ts_q[0].delete();
      ts_q[2].delete();
      ch_enable = 4'b0010;
      refresh();
      for (int i = 0; i < 3; i++) begin
         serve(2, (i == 1), got);
         check("only_ch1", got, 1);
         ts_q[1].push_back(TS_WIDTH'($urandom));
         refresh();
      end

      for (int it = 0; it < 30; it++) begin
         ch_enable = NUM_CHANNELS'($urandom_range(0, 15));
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if ($urandom_range(0, 1) == 1 && ts_q[i].size() < 4) ts_q[i].push_back(TS_WIDTH'($urandom));
         end
         refresh();
         if ((ch_valid & ch_enable) == '0) begin
            repeat (3) step();
            check("no_elig_idle", {31'd0, dat_rdy}, 32'd0);
         end else begin
            serve($urandom_range(0, 3), 1'(($urandom_range(0, 1))), got);
         end
      end

      // Reset during POP drops the pop and restores channel-0 priority.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (ts_q[i].size() == 0) ts_q[i].push_back(TS_WIDTH'($urandom));
      end
      ch_enable = '1;
      refresh();
      exp_ch = rr_next(ch_valid & ch_enable, exp_last);
      wait_rdy();
      word_fetched = 1'b1;
      step();
      word_fetched = 1'b0;
      check("rstpop_pop", 32'(ch_pop), 32'(1) << exp_ch);
      rst_n = 1'b0;
      #1;
      check("rstpop_ch_pop", 32'(ch_pop), 32'd0);
      check("rstpop_dat_rdy", {31'd0, dat_rdy}, 32'd0);
      check("rstpop_word", 32'(word_to_tx), 32'd0);
      check("rstpop_grant", 32'(grant_id), 32'd0);
      check("rstpop_underrun", {31'd0, underrun}, 32'd0);
      step();
      rst_n    = 1'b1;
      exp_last = NUM_CHANNELS - 1;
      serve(0, 1'b0, got);
      check("rstpop_first", got, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
